// File: rtl/captura_pkg.sv
// Shared definitions for the frame-capture sequencer.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
// Contents: default geometry constants, FSM state encodings, saturating increment.
package captura_pkg;

  localparam int CAP_ADDR_W         = 15;
  localparam int CAP_MAX_ADDR       = 19199;   // 160x120 downsampled frame, last word
  localparam int CAP_RAW_LINES      = 480;     // HREF rising edges in a full VGA frame
  localparam int CAP_TIMEOUT_CYCLES = 2000000;
  localparam int LINE_W             = 10;
  localparam int WD_W               = 21;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [LINE_W-1:0] sat_inc(input logic [LINE_W-1:0] v);
    return (&v) ? v : v + LINE_W'(1);
  endfunction

endpackage

// File: rtl/captura_if.sv
// Write path between the downsampler, the capture sequencer and the frame-buffer RAM.
// Latency: n/a (wires only); wr_out is a combinational gate of wr_in.
// Backpressure: none; the RAM always accepts a write.
// master: downsampler side (drives wr_in/addr_in, sees wr_out).
// slave : sequencer side (sees wr_in/addr_in, drives wr_out).
interface captura_if
  import captura_pkg::*;
#(
  parameter int ADDR_W = CAP_ADDR_W
) ();

  logic              wr_in;
  logic [ADDR_W-1:0] addr_in;
  logic              wr_out;

  modport master (output wr_in, output addr_in, input wr_out);
  modport slave  (input wr_in, input addr_in, output wr_out);

endinterface

// File: rtl/captura_edge_det.sv
// Registers an asynchronous camera strobe once and flags its edges.
// Latency: rise/fall are valid one cycle after the pin changes.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), din (raw pin) -> rise, fall (1-cycle pulses).
module captura_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic cur_q, cur_d;
  logic prev_q, prev_d;

  always_comb begin
    cur_d  = din;
    prev_d = cur_q;
  end

  // Both stages reset low so a pin that is high out of reset shows up as a
  // rise (harmless to the sequencer) and never as a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      prev_q <= prev_d;
    end
  end

  assign rise = cur_q & ~prev_q;
  assign fall = ~cur_q & prev_q;

endmodule

// File: rtl/captura_control.sv
// Frame-capture sequencer: arms on start, gates RAM writes to one VSYNC-bounded frame.
// Latency: write gating is combinational (0 cycles); VSYNC/HREF edges act 2 cycles after the pin.
// Backpressure: none; writes outside an active frame or beyond MAX_ADDR are dropped.
// Ports: PCLK, rst (sync, active-high), VSYNC, HREF, start, continuous, abort,
//        wr_if (slave: wr_in/addr_in in, wr_out out), cap_en, busy, frame_done,
//        frame_ok, overflow, line_cnt[9:0]; plus timeout when CAPTURA_TIMEOUT_EN is defined.
// Optional watchdog: define CAPTURA_TIMEOUT_EN to add the TIMEOUT_CYCLES parameter and timeout port.
module captura_control
  import captura_pkg::*;
#(
  parameter int ADDR_W    = CAP_ADDR_W,
  parameter int MAX_ADDR  = CAP_MAX_ADDR,
  parameter int RAW_LINES = CAP_RAW_LINES
`ifdef CAPTURA_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = CAP_TIMEOUT_CYCLES
`endif
) (
  input  logic              PCLK,
  input  logic              rst,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  captura_if.slave          wr_if,
  output logic              cap_en,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              overflow,
  output logic [LINE_W-1:0] line_cnt
`ifdef CAPTURA_TIMEOUT_EN
  , output logic            timeout
`endif
);

  logic vs_rise, vs_fall, href_rise;
  logic href_fall_unused;

  captura_edge_det u_vs_edge (
    .clk  (PCLK),
    .rst  (rst),
    .din  (VSYNC),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  captura_edge_det u_href_edge (
    .clk  (PCLK),
    .rst  (rst),
    .din  (HREF),
    .rise (href_rise),
    .fall (href_fall_unused)
  );

  logic [1:0]        state_q, state_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic              overflow_q, overflow_d;
  logic              frame_ok_q, frame_ok_d;
`ifdef CAPTURA_TIMEOUT_EN
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              timeout_q, timeout_d;
`endif

  logic in_cap;
  logic addr_legal;

  assign in_cap     = (state_q == ST_CAPTURE);
  assign addr_legal = (wr_if.addr_in <= ADDR_W'(MAX_ADDR));

  // rst gates the strobe directly so no write escapes in the cycle reset is
  // first seen, before state_q has had a chance to return to IDLE.
  assign wr_if.wr_out = wr_if.wr_in && in_cap && addr_legal && !rst;

  always_comb begin
    state_d    = state_q;
    line_cnt_d = line_cnt_q;
    overflow_d = overflow_q;
    frame_ok_d = frame_ok_q;
`ifdef CAPTURA_TIMEOUT_EN
    timeout_d  = timeout_q;
    wd_d       = wd_q;
`endif

    if (in_cap && wr_if.wr_in && !addr_legal) begin
      overflow_d = 1'b1;
    end

    if (in_cap && href_rise) begin
      line_cnt_d = sat_inc(line_cnt_q);
    end

    case (state_q)
      ST_IDLE:    if (start)   state_d = ST_ARM;
      ST_ARM:     if (vs_fall) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (vs_rise) begin
          state_d    = ST_DONE;
          // overflow_d so a bad write in the closing cycle still spoils the frame
          frame_ok_d = (line_cnt_q == LINE_W'(RAW_LINES)) && !overflow_d;
        end
      end
      default:    state_d = continuous ? ST_ARM : ST_IDLE;
    endcase

`ifdef CAPTURA_TIMEOUT_EN
    if ((state_q == ST_ARM || state_q == ST_CAPTURE) &&
        wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
      state_d    = ST_IDLE;
      timeout_d  = 1'b1;
      frame_ok_d = frame_ok_q;
    end
`endif

    // abort overrides every transition, including a frame that is closing now
    if (abort) begin
      state_d    = ST_IDLE;
      frame_ok_d = frame_ok_q;
    end

    // Fresh frame statistics on every entry to ARM (from IDLE or a re-arm).
    if (state_d == ST_ARM && state_q != ST_ARM) begin
      line_cnt_d = '0;
      overflow_d = 1'b0;
`ifdef CAPTURA_TIMEOUT_EN
      timeout_d  = 1'b0;
`endif
    end

`ifdef CAPTURA_TIMEOUT_EN
    if (state_d != state_q || !(state_d == ST_ARM || state_d == ST_CAPTURE)) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
`endif
  end

  always_ff @(posedge PCLK) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      line_cnt_q <= '0;
      overflow_q <= 1'b0;
      frame_ok_q <= 1'b0;
`ifdef CAPTURA_TIMEOUT_EN
      wd_q       <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      line_cnt_q <= line_cnt_d;
      overflow_q <= overflow_d;
      frame_ok_q <= frame_ok_d;
`ifdef CAPTURA_TIMEOUT_EN
      wd_q       <= wd_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign cap_en     = (state_q == ST_ARM) || (state_q == ST_CAPTURE);
  assign frame_done = (state_q == ST_DONE);
  assign frame_ok   = frame_ok_q;
  assign overflow   = overflow_q;
  assign line_cnt   = line_cnt_q;
`ifdef CAPTURA_TIMEOUT_EN
  assign timeout    = timeout_q;
`endif

endmodule
